// File: rtl/scr1_ahb_resp_mem_pkg.sv
// Shared AHB-Lite encodings and types for the wait-state/ERROR responder memory.
package scr1_ahb_resp_mem_pkg;

  localparam int unsigned SCR1_AHB_WIDTH  = 32;
  localparam int unsigned SCR1_AHB_BE_W   = SCR1_AHB_WIDTH / 8;
  localparam int unsigned SCR1_STALL_W    = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] SCR1_HSIZE_8  = 3'd0;
  localparam logic [2:0] SCR1_HSIZE_16 = 3'd1;
  localparam logic [2:0] SCR1_HSIZE_32 = 3'd2;

  typedef enum logic [1:0] {
    SCR1_AHB_RESP_FSM_IDLE = 2'd0,
    SCR1_AHB_RESP_FSM_DATA = 2'd1,
    SCR1_AHB_RESP_FSM_ERR1 = 2'd2,
    SCR1_AHB_RESP_FSM_ERR2 = 2'd3
  } type_scr1_ahb_resp_fsm_e;

endpackage

// File: rtl/scr1_ahb_resp_ram.sv
// Word-organised storage with per-byte write enables and asynchronous read; never reset.
module scr1_ahb_resp_ram
  import scr1_ahb_resp_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic                      clk,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [SCR1_AHB_BE_W-1:0]  we,
  input  logic [SCR1_AHB_WIDTH-1:0] wdata,
  output logic [SCR1_AHB_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [SCR1_AHB_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(SCR1_AHB_BE_W); i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/scr1_ahb_resp_mem.sv
// AHB-Lite single-slave word memory with a rotating wait-state pattern and two-cycle ERROR responses.
module scr1_ahb_resp_mem
  import scr1_ahb_resp_mem_pkg::*;
#(
  parameter int unsigned SCR1_MEM_POWER_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SCR1_STALL_W-1:0]   stall_pattern_in,
  input  logic [1:0]                htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] haddr,
  input  logic [2:0]                hsize,
  input  logic                      hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0] hwdata,
  output logic                      hready,
  output logic [SCR1_AHB_WIDTH-1:0] hrdata,
  output logic                      hresp
);

  localparam int unsigned WORD_AW = SCR1_MEM_POWER_SIZE - 2;
  localparam logic [SCR1_AHB_WIDTH:0] MEM_LIMIT =
    (SCR1_AHB_WIDTH+1)'(1) << SCR1_MEM_POWER_SIZE;

  type_scr1_ahb_resp_fsm_e state_r;
  type_scr1_ahb_resp_fsm_e state_next;
  type_scr1_ahb_resp_fsm_e new_xfer_state;

  logic [SCR1_STALL_W-1:0]   pattern_r;
  logic                      pattern_loaded_r;
  logic [WORD_AW-1:0]        waddr_r;
  logic [SCR1_AHB_BE_W-1:0]  be_r;
  logic                      hwrite_r;

  logic                      xfer_req;
  logic                      accept;
  logic                      addr_err;
  logic [SCR1_AHB_BE_W-1:0]  be_dec;
  logic [SCR1_AHB_BE_W-1:0]  ram_we;
  logic [SCR1_AHB_WIDTH-1:0] ram_rdata;

  // Only NONSEQ/SEQ start a transfer
  always_comb begin
    xfer_req = 1'b0;
    case (htrans)
      SCR1_HTRANS_NONSEQ, SCR1_HTRANS_SEQ: xfer_req = 1'b1;
      SCR1_HTRANS_IDLE,   SCR1_HTRANS_BUSY: xfer_req = 1'b0;
    endcase
  end

  assign accept = hready & xfer_req;

  // Address-phase decode: byte lanes and illegal size/alignment/range
  always_comb begin
    addr_err = 1'b0;
    be_dec   = '0;
    case (hsize)
      SCR1_HSIZE_8: begin
        be_dec = SCR1_AHB_BE_W'(1) << haddr[1:0];
      end
      SCR1_HSIZE_16: begin
        be_dec   = haddr[1] ? 4'b1100 : 4'b0011;
        addr_err = haddr[0];
      end
      SCR1_HSIZE_32: begin
        be_dec   = '1;
        addr_err = |haddr[1:0];
      end
      default: begin
        addr_err = 1'b1;
      end
    endcase
    if ({1'b0, haddr} >= MEM_LIMIT) begin
      addr_err = 1'b1;
    end
  end

  // Wait-state pattern: loaded once after reset, then rotates every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r        <= '1;
      pattern_loaded_r <= 1'b0;
    end else if (!pattern_loaded_r) begin
      pattern_r        <= (stall_pattern_in == '0) ? '1 : stall_pattern_in;
      pattern_loaded_r <= 1'b1;
    end else begin
      pattern_r        <= {pattern_r[0], pattern_r[SCR1_STALL_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SCR1_AHB_RESP_FSM_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  always_comb begin
    new_xfer_state = SCR1_AHB_RESP_FSM_IDLE;
    state_next     = state_r;
    if (accept) begin
      new_xfer_state = addr_err ? SCR1_AHB_RESP_FSM_ERR1 : SCR1_AHB_RESP_FSM_DATA;
    end
    case (state_r)
      SCR1_AHB_RESP_FSM_IDLE: state_next = new_xfer_state;
      SCR1_AHB_RESP_FSM_DATA: begin
        if (pattern_r[0]) begin
          state_next = new_xfer_state;
        end
      end
      SCR1_AHB_RESP_FSM_ERR1: state_next = SCR1_AHB_RESP_FSM_ERR2;
      SCR1_AHB_RESP_FSM_ERR2: state_next = new_xfer_state;
      default:                state_next = SCR1_AHB_RESP_FSM_IDLE;
    endcase
  end

  // Response outputs depend only on registered state
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state_r)
      SCR1_AHB_RESP_FSM_DATA: begin
        hready = pattern_r[0];
        hrdata = ram_rdata;
      end
      SCR1_AHB_RESP_FSM_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      SCR1_AHB_RESP_FSM_ERR2: begin
        hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_r  <= '0;
      be_r     <= '0;
      hwrite_r <= 1'b0;
    end else if (accept) begin
      waddr_r  <= haddr[SCR1_MEM_POWER_SIZE-1:2];
      be_r     <= be_dec;
      hwrite_r <= hwrite;
    end
  end

  // Writes land only on the completing data-phase cycle
  always_comb begin
    ram_we = '0;
    if ((state_r == SCR1_AHB_RESP_FSM_DATA) && pattern_r[0] && hwrite_r) begin
      ram_we = be_r;
    end
  end

  scr1_ahb_resp_ram #(
    .ADDR_W (WORD_AW)
  ) i_ram (
    .clk   (clk),
    .addr  (waddr_r),
    .we    (ram_we),
    .wdata (hwdata),
    .rdata (ram_rdata)
  );

endmodule
